alu_flag_unit: RTL and testbench
================================

// Module: alu_flag_unit
// PURPOSE
//  8-bit execution unit sitting directly upstream of the flag register. Accepts one op per
//  handshake, produces the result and the Z/N/C/V flag byte, and drives the flag register's
//  f[7:0]/s[2:0] inputs every cycle. Single-cycle ALU ops plus a multi-cycle shift-add MUL.
// PARAMETERS
//  WIDTH    8   operand/result width; the flag byte stays 8 bits regardless
// PORTS
//  clk        in   1      single clock, all state on posedge
//  reset      in   1      asynchronous, active-high; clears all state immediately
//  in_valid   in   1      op/a/b valid this cycle
//  in_ready   out  1      unit can accept; transfer = in_valid & in_ready at posedge clk
//  op         in   4      opcode, see BEHAVIOUR
//  a, b       in   WIDTH  operands
//  result     out  WIDTH  registered result, valid when res_valid=1
//  res_valid  out  1      one-cycle pulse per accepted op
//  busy       out  1      1 while in MUL state
//  f          out  8      flag byte to flag register: [0]Z [1]N [2]C [3]V, [7:4]=0
//  s          out  3      flag register select: 3'b100 = load f, 3'b0ii = set flag ii
// BEHAVIOUR
//  Reset: state=IDLE, result=0, res_valid=0, busy=0, flags_q=0, f=0, s=3'b100.
//  Opcodes: 0 ADD, 1 SUB (a-b), 2 AND, 3 OR, 4 XOR, 5 SHL (a<<1), 6 SHR (a>>1 logical),
//   7 MUL (unsigned, low WIDTH bits to result), 8-11 SETZ/SETN/SETC/SETV, 12 CLRF, 13-15 NOP.
//  Flags (ALU ops 0-7): Z = result==0; N = result[WIDTH-1];
//   C: ADD carry-out, SUB borrow (a<b unsigned), SHL a[WIDTH-1], SHR a[0], MUL upper half!=0,
//   logic ops 0; V: ADD/SUB two's-complement signed overflow, MUL = C, all others 0.
//  FSM IDLE: in_ready=1. Accept of op!=7 -> next cycle result/flags registered, res_valid=1
//   (latency 1), stay IDLE, back-to-back accepts allowed every cycle.
//   Accept of MUL -> load multiplicand/multiplier, count=0, go MUL.
//  FSM MUL: in_ready=0, busy=1, one shift-add step per cycle, in_valid ignored; after WIDTH
//   steps -> result/flags registered, res_valid=1 in that same cycle as return to IDLE
//   (accept-to-res_valid = WIDTH+1 cycles). No new op accepted until back in IDLE.
//  f/s: f = flags_q always. s = 3'b100 every cycle except the cycle after a SETx accept, where
//   s = {1'b0, idx} for exactly one cycle; flags_q bit idx set at that same edge so f and the
//   downstream register agree. CLRF: flags_q <= 0 (loaded via s=100). NOP: flags unchanged.
//  SETx/CLRF/NOP still pulse res_valid with result=0 and leave flag semantics as above.
//  Reset mid-MUL: abort, no res_valid, flags_q=0; downstream register reloads 0 next edge.
//  Arithmetic: ADD/SUB in WIDTH+1 bits; MUL product in 2*WIDTH bits; no saturation.
// STRUCTURE
//  alu_pkg: op_e opcode enum, FLAG_Z/N/C/V index constants, SEL_LOAD=3'b100, state_e {IDLE,MUL}.
//  Sub-module seq_multiplier (start, done, a, b, prod[2*WIDTH-1:0]); FSM, ALU and flag
//  logic stay in alu_flag_unit.
// TESTING
//  reset asserted mid-stream -> result=0,res_valid=0,f=8'h00,s=3'b100 same cycle, in_ready=1
//  ADD a=8'h7F b=8'h01 -> 1 cycle: result=8'h80, f=8'b0000_1010 (N,V), s=3'b100
//  SUB a=8'h05 b=8'h05 then ADD a=8'hFF b=8'h01 back-to-back -> f=8'h01 then f=8'h05 (Z,C)
//  MUL a=8'h10 b=8'h10 -> in_ready=0 for 8 cycles, res_valid at cycle 9, result=8'h00,
//   f=8'h0D (Z,C,V); in_valid during busy ignored
//  SETC in IDLE with flags 0 -> s=3'b010 one cycle then 3'b100, f=8'h04 from that cycle on
//  MUL a=8'h03 b=8'h03, reset at cycle 4 -> no res_valid, f=0, next ADD accepted normally

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode, flag-index, select and FSM-state definitions for the ALU flag unit.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_SHL  = 4'd5,
    OP_SHR  = 4'd6,
    OP_MUL  = 4'd7,
    OP_SETZ = 4'd8,
    OP_SETN = 4'd9,
    OP_SETC = 4'd10,
    OP_SETV = 4'd11,
    OP_CLRF = 4'd12,
    OP_NOP  = 4'd13
  } op_e;

  localparam int unsigned FLAG_Z = 0;
  localparam int unsigned FLAG_N = 1;
  localparam int unsigned FLAG_C = 2;
  localparam int unsigned FLAG_V = 3;

  localparam logic [2:0] SEL_LOAD = 3'b100;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_e;

  function automatic logic [3:0] pack_flags(input logic z, input logic n,
                                            input logic c, input logic v);
    logic [3:0] fl;
    fl         = 4'b0000;
    fl[FLAG_Z] = z;
    fl[FLAG_N] = n;
    fl[FLAG_C] = c;
    fl[FLAG_V] = v;
    return fl;
  endfunction

endpackage

// File: rtl/seq_multiplier.sv
// Unsigned shift-add multiplier: one partial-product step per cycle after start.
// done is high during the last step, with prod already showing the final product.
module seq_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] prod
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [CW-1:0]      count_q;
  logic               running_q;

  // Accumulate the shifted multiplicand when the current multiplier bit is set.
  always_comb begin
    if (mplier_q[0]) begin
      acc_d = acc_q + mcand_q;
    end else begin
      acc_d = acc_q;
    end
  end

  assign done = running_q && (count_q == LAST);
  assign prod = acc_d;

  // Step state: load on start, then shift one bit per cycle until the last step.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q     <= {(2*WIDTH){1'b0}};
      mcand_q   <= {(2*WIDTH){1'b0}};
      mplier_q  <= {WIDTH{1'b0}};
      count_q   <= {CW{1'b0}};
      running_q <= 1'b0;
    end else if (start) begin
      acc_q     <= {(2*WIDTH){1'b0}};
      mcand_q   <= {{WIDTH{1'b0}}, a};
      mplier_q  <= b;
      count_q   <= {CW{1'b0}};
      running_q <= 1'b1;
    end else if (running_q) begin
      acc_q     <= acc_d;
      mcand_q   <= {mcand_q[2*WIDTH-2:0], 1'b0};
      mplier_q  <= {1'b0, mplier_q[WIDTH-1:1]};
      count_q   <= count_q + CW'(1);
      running_q <= !done;
    end else begin
      running_q <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_flag_unit.sv
// 8-bit execution unit: single-cycle ALU ops, multi-cycle MUL, and the Z/N/C/V flag byte
// plus load/set select that drive the downstream flag register every cycle.
module alu_flag_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             res_valid,
  output logic             busy,
  output logic [7:0]       f,
  output logic [2:0]       s
);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               res_valid_q, res_valid_d;
  logic [3:0]         flags_q, flags_d;
  logic [2:0]         sel_q, sel_d;

  logic               accept_s;
  logic               mul_start_s;
  logic               mul_done_s;
  logic [2*WIDTH-1:0] prod_s;
  logic               prod_hi_s;
  logic [WIDTH:0]     sum_s;
  logic [WIDTH:0]     diff_s;
  logic [WIDTH-1:0]   alu_res_s;
  logic               alu_c_s;
  logic               alu_v_s;

  seq_multiplier #(.WIDTH(WIDTH)) u_mul (
    .clk   (clk),
    .reset (reset),
    .start (mul_start_s),
    .a     (a),
    .b     (b),
    .done  (mul_done_s),
    .prod  (prod_s)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: MUL is entered on a MUL accept and left on the final step.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (mul_start_s) begin
          state_d = MUL;
        end else begin
          state_d = IDLE;
        end
      end
      MUL: begin
        if (mul_done_s) begin
          state_d = IDLE;
        end else begin
          state_d = MUL;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    case (state_q)
      IDLE:    in_ready = 1'b1;
      MUL:     busy     = 1'b1;
      default: in_ready = 1'b0;
    endcase
  end

  assign accept_s    = in_valid && in_ready;
  assign mul_start_s = accept_s && (op == OP_MUL);
  assign prod_hi_s   = |prod_s[2*WIDTH-1:WIDTH];

  // Single-cycle ALU datapath; carry/overflow come from the WIDTH+1 bit sum/difference.
  always_comb begin
    sum_s     = {1'b0, a} + {1'b0, b};
    diff_s    = {1'b0, a} - {1'b0, b};
    alu_res_s = {WIDTH{1'b0}};
    alu_c_s   = 1'b0;
    alu_v_s   = 1'b0;
    case (op_e'(op))
      OP_ADD: begin
        alu_res_s = sum_s[WIDTH-1:0];
        alu_c_s   = sum_s[WIDTH];
        alu_v_s   = (a[WIDTH-1] == b[WIDTH-1]) && (sum_s[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res_s = diff_s[WIDTH-1:0];
        alu_c_s   = diff_s[WIDTH];
        alu_v_s   = (a[WIDTH-1] != b[WIDTH-1]) && (diff_s[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: alu_res_s = a & b;
      OP_OR:  alu_res_s = a | b;
      OP_XOR: alu_res_s = a ^ b;
      OP_SHL: begin
        alu_res_s = {a[WIDTH-2:0], 1'b0};
        alu_c_s   = a[WIDTH-1];
      end
      OP_SHR: begin
        alu_res_s = {1'b0, a[WIDTH-1:1]};
        alu_c_s   = a[0];
      end
      default: alu_res_s = {WIDTH{1'b0}};
    endcase
  end

  // Result, flag and select next-state; SETx flags index directly from op[1:0].
  always_comb begin
    result_d    = result_q;
    flags_d     = flags_q;
    res_valid_d = 1'b0;
    sel_d       = SEL_LOAD;
    if (accept_s && (op != OP_MUL)) begin
      res_valid_d = 1'b1;
      result_d    = {WIDTH{1'b0}};
      case (op_e'(op))
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR: begin
          result_d = alu_res_s;
          flags_d  = pack_flags(alu_res_s == {WIDTH{1'b0}}, alu_res_s[WIDTH-1],
                                alu_c_s, alu_v_s);
        end
        OP_SETZ, OP_SETN, OP_SETC, OP_SETV: begin
          flags_d[op[1:0]] = 1'b1;
          sel_d            = {1'b0, op[1:0]};
        end
        OP_CLRF: flags_d = 4'b0000;
        default: flags_d = flags_q;
      endcase
    end else if (mul_done_s) begin
      res_valid_d = 1'b1;
      result_d    = prod_s[WIDTH-1:0];
      flags_d     = pack_flags(prod_s[WIDTH-1:0] == {WIDTH{1'b0}}, prod_s[WIDTH-1],
                               prod_hi_s, prod_hi_s);
    end else begin
      res_valid_d = 1'b0;
    end
  end

  // Output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result_q    <= {WIDTH{1'b0}};
      res_valid_q <= 1'b0;
      flags_q     <= 4'b0000;
      sel_q       <= SEL_LOAD;
    end else begin
      result_q    <= result_d;
      res_valid_q <= res_valid_d;
      flags_q     <= flags_d;
      sel_q       <= sel_d;
    end
  end

  assign result    = result_q;
  assign res_valid = res_valid_q;
  assign f         = {4'b0000, flags_q};
  assign s         = sel_q;

endmodule

// File: tb/tb_alu_flag_unit.sv
// Scoreboard bench for alu_flag_unit: directed ops push expected result/f/s,
// a negedge monitor pops and compares on every res_valid pulse.
module tb_alu_flag_unit;
  import alu_pkg::*;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] fl;
    logic [2:0] sel;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] op;
  logic [7:0] a;
  logic [7:0] b;
  logic [7:0] result;
  logic       res_valid;
  logic       busy;
  logic [7:0] f;
  logic [2:0] s;

  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];
  exp_t mon_e;

  alu_flag_unit #(.WIDTH(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .result    (result),
    .res_valid (res_valid),
    .busy      (busy),
    .f         (f),
    .s         (s)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (!reset && res_valid) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_res_valid: got result %0h f %0h, nothing expected", result, f);
      end else begin
        mon_e = sb_q.pop_front();
        chk("result", result, mon_e.r);
        chk("f", f, mon_e.fl);
        chk("s", 8'(s), 8'(mon_e.sel));
      end
    end
  end

  task automatic issue(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y,
                       input logic [7:0] er, input logic [7:0] ef, input logic [2:0] es);
    exp_t t;
    t.r   = er;
    t.fl  = ef;
    t.sel = es;
    sb_q.push_back(t);
    op       = o;
    a        = x;
    b        = y;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!in_ready && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: in_ready still %0b after %0d cycles", in_ready, n);
    end
  endtask

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    op       = 4'd0;
    a        = 8'h00;
    b        = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_result", result, 8'h00);
    chk("rst_res_valid", 8'(res_valid), 8'h00);
    chk("rst_f", f, 8'h00);
    chk("rst_s", 8'(s), 8'h04);
    chk("rst_in_ready", 8'(in_ready), 8'h01);
    chk("rst_busy", 8'(busy), 8'h00);
    @(posedge clk);
    #1;

    // Single-cycle ALU ops, issued back-to-back.
    issue(OP_ADD, 8'h7F, 8'h01, 8'h80, 8'h0A, 3'b100);
    issue(OP_SUB, 8'h05, 8'h05, 8'h00, 8'h01, 3'b100);
    issue(OP_ADD, 8'hFF, 8'h01, 8'h00, 8'h05, 3'b100);
    issue(OP_AND, 8'hF0, 8'h3C, 8'h30, 8'h00, 3'b100);
    issue(OP_OR,  8'h80, 8'h01, 8'h81, 8'h02, 3'b100);
    issue(OP_XOR, 8'hAA, 8'hAA, 8'h00, 8'h01, 3'b100);
    issue(OP_SHL, 8'h81, 8'h00, 8'h02, 8'h04, 3'b100);
    issue(OP_SHR, 8'h01, 8'h00, 8'h00, 8'h05, 3'b100);
    issue(OP_SUB, 8'h00, 8'h01, 8'hFF, 8'h06, 3'b100);
    issue(OP_SUB, 8'h80, 8'h01, 8'h7F, 8'h08, 3'b100);
    issue(OP_ADD, 8'h80, 8'h80, 8'h00, 8'h0D, 3'b100);

    // MUL with exact latency and in_valid held high while busy.
    issue(OP_MUL, 8'h10, 8'h10, 8'h00, 8'h0D, 3'b100);
    op       = OP_ADD;
    a        = 8'h01;
    b        = 8'h01;
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("mul_in_ready", 8'(in_ready), 8'h00);
      chk("mul_busy", 8'(busy), 8'h01);
      chk("mul_early_valid", 8'(res_valid), 8'h00);
      @(posedge clk);
    end
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("mul_res_valid", 8'(res_valid), 8'h01);
    chk("mul_idle_ready", 8'(in_ready), 8'h01);
    @(posedge clk);
    #1;

    issue(OP_MUL, 8'h0F, 8'h03, 8'h2D, 8'h00, 3'b100);
    wait_idle();
    issue(OP_MUL, 8'hFF, 8'hFF, 8'h01, 8'h0C, 3'b100);
    wait_idle();

    // Flag-register control ops.
    issue(OP_CLRF, 8'h12, 8'h34, 8'h00, 8'h00, 3'b100);
    issue(OP_SETC, 8'h00, 8'h00, 8'h00, 8'h04, 3'b010);
    issue(OP_NOP,  8'h00, 8'h00, 8'h00, 8'h04, 3'b100);
    issue(OP_SETZ, 8'h00, 8'h00, 8'h00, 8'h05, 3'b000);
    issue(OP_SETV, 8'h00, 8'h00, 8'h00, 8'h0D, 3'b011);
    issue(OP_SETN, 8'h00, 8'h00, 8'h00, 8'h0F, 3'b001);
    issue(4'd15,   8'h00, 8'h00, 8'h00, 8'h0F, 3'b100);
    @(negedge clk);
    chk("idle_s_load", 8'(s), 8'h04);
    @(posedge clk);
    #1;

    // MUL aborted by reset: no result, flags cleared at once.
    op       = OP_MUL;
    a        = 8'h03;
    b        = 8'h03;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("abort_result", result, 8'h00);
    chk("abort_res_valid", 8'(res_valid), 8'h00);
    chk("abort_f", f, 8'h00);
    chk("abort_s", 8'(s), 8'h04);
    chk("abort_in_ready", 8'(in_ready), 8'h01);
    chk("abort_busy", 8'(busy), 8'h00);
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (12) @(posedge clk);
    @(negedge clk);
    chk("post_abort_f", f, 8'h00);
    @(posedge clk);
    #1;
    issue(OP_ADD, 8'h02, 8'h03, 8'h05, 8'h00, 3'b100);

    for (int n = 0; n < 10 && sb_q.size() != 0; n++) begin
      @(posedge clk);
    end
    @(negedge clk);
    chk("sb_drained", 8'(sb_q.size()), 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
